// File: rtl/up_writeback_ctrl_if.sv
// Bundle of the start/hold controls, the memory read/write strobes and the
// update-processor data buses seen by the write-back sequencer.
interface up_writeback_ctrl_if #(
    parameter int z     = 32,
    parameter int fi    = 16,
    parameter int width = 10,
    parameter int depth = 64
);
    localparam int aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int ww = width * z;
    localparam int bw = width * (z / fi);

    logic          start;
    logic          hold;
    logic          rd_en;
    logic [aw-1:0] rd_addr;
    logic [ww-1:0] wt_UP_package;
    logic [bw-1:0] bias_UP_package;
    logic          wr_en;
    logic [aw-1:0] wr_addr;
    logic [ww-1:0] wr_wt_data;
    logic [bw-1:0] wr_bias_data;
    logic          busy;
    logic          done;

    // The sequencer masters the memory side; the environment drives controls and data.
    modport master (
        input  start, hold, wt_UP_package, bias_UP_package,
        output rd_en, rd_addr, wr_en, wr_addr, wr_wt_data, wr_bias_data, busy, done
    );

    modport slave (
        output start, hold, wt_UP_package, bias_UP_package,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_wt_data, wr_bias_data, busy, done
    );
endinterface

// File: rtl/up_writeback_ctrl.sv
// Weight-update pass sequencer: issues reads, tracks each address through the
// memory + update pipeline latency, and writes the updated words back in place.
module up_writeback_ctrl #(
    parameter int z      = 32,
    parameter int fi     = 16,
    parameter int width  = 10,
    parameter int depth  = 64,
    parameter int memlat = 1,
    parameter int uplat  = 6
) (
    input logic clk,
    input logic reset,
    up_writeback_ctrl_if.master bus
);
    localparam int D  = memlat + uplat;
    localparam int aw = (depth > 1) ? $clog2(depth) : 1;
    localparam int ww = width * z;
    localparam int bw = width * (z / fi);
    localparam logic [aw-1:0] LAST = aw'(depth - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state_q;
    logic [aw-1:0] rdCnt_q;
    logic          busy_q;
    logic          done_q;

    logic          rdEn;
    logic [aw-1:0] rdAddr;
    logic          tapValid;
    logic [aw-1:0] tapAddr;
    logic          lineBusy;

    logic          wrEn_q,   wrEn_d;
    logic [aw-1:0] wrAddr_q, wrAddr_d;
    logic [ww-1:0] wrWt_q,   wrWt_d;
    logic [bw-1:0] wrBias_q, wrBias_d;

    always_comb begin
        rdEn   = (state_q == ISSUE) && !bus.hold;
        rdAddr = rdEn ? rdCnt_q : '0;
    end

    // Sequencer FSM; busy/done are registered alongside the state transitions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rdCnt_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= ISSUE;
                        rdCnt_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!bus.hold) begin
                        if (rdCnt_q == LAST) begin
                            state_q <= DRAIN;
                        end else begin
                            rdCnt_q <= rdCnt_q + aw'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!lineBusy) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // With zero total latency the tag is the live read strobe itself.
    if (D > 0) begin : g_line
        logic [D-1:0]  valid_q, valid_d;
        logic [aw-1:0] addr_q [D];
        logic [aw-1:0] addr_d [D];

        always_comb begin
            valid_d[0] = rdEn;
            addr_d[0]  = rdAddr;
            for (int i = 1; i < D; i++) begin
                valid_d[i] = valid_q[i-1];
                addr_d[i]  = addr_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                valid_q <= '0;
                for (int i = 0; i < D; i++) begin
                    addr_q[i] <= '0;
                end
            end else begin
                valid_q <= valid_d;
                addr_q  <= addr_d;
            end
        end

        assign tapValid = valid_q[D-1];
        assign tapAddr  = addr_q[D-1];
        assign lineBusy = |valid_q;
    end else begin : g_noline
        assign tapValid = rdEn;
        assign tapAddr  = rdAddr;
        assign lineBusy = 1'b0;
    end

    always_comb begin
        wrEn_d   = tapValid;
        wrAddr_d = wrAddr_q;
        wrWt_d   = wrWt_q;
        wrBias_d = wrBias_q;
        if (tapValid) begin
            wrAddr_d = tapAddr;
            wrWt_d   = bus.wt_UP_package;
            wrBias_d = bus.bias_UP_package;
        end
    end

    // Write port registers; data and address hold their last values between writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrWt_q   <= '0;
            wrBias_q <= '0;
        end else begin
            wrEn_q   <= wrEn_d;
            wrAddr_q <= wrAddr_d;
            wrWt_q   <= wrWt_d;
            wrBias_q <= wrBias_d;
        end
    end

    assign bus.rd_en        = rdEn;
    assign bus.rd_addr      = rdAddr;
    assign bus.wr_en        = wrEn_q;
    assign bus.wr_addr      = wrAddr_q;
    assign bus.wr_wt_data   = wrWt_q;
    assign bus.wr_bias_data = wrBias_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_up_writeback_ctrl.sv
// Bench for up_writeback_ctrl: three configurations (default, depth 4 with hold,
// zero latency) checked against a scoreboard of expected write-backs.
module tb_up_writeback_ctrl;
    typedef struct {
        int           cyc;
        int           addr;
        logic [319:0] wt;
        logic [19:0]  bias;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nAssert = 0;
    int   nFail = 0;

    wr_t  expA[$];
    wr_t  expB[$];
    wr_t  expC[$];
    int   expDoneA = -1, expDoneB = -1, expDoneC = -1;
    int   doneCntA = 0, doneCntB = 0, doneCntC = 0;

    up_writeback_ctrl_if #(.depth(64)) busA();
    up_writeback_ctrl_if #(.depth(4))  busB();
    up_writeback_ctrl_if #(.depth(2))  busC();

    up_writeback_ctrl #(.depth(64)) dutA (.clk(clk), .reset(reset), .bus(busA));
    up_writeback_ctrl #(.depth(4))  dutB (.clk(clk), .reset(reset), .bus(busB));
    up_writeback_ctrl #(.depth(2), .memlat(0), .uplat(0)) dutC (.clk(clk), .reset(reset), .bus(busC));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [319:0] wtOf(input logic [7:0] a);
        return {40{a}};
    endfunction

    function automatic logic [19:0] biasOf(input logic [7:0] a);
        return {a, ~a, 4'ha};
    endfunction

    task automatic checkOutput(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkWrite(input string who, input int n, input wr_t e, input logic [7:0] addr,
                              input logic [319:0] wt, input logic [19:0] bias);
        nAssert++;
        assert (n != 0) else begin
            nFail++;
            $error("[TB] FAIL %s.wr_unexpected: write addr %0d in cycle %0d, expected no write", who, addr, cyc);
        end
        if (n != 0) begin
            checkOutput({who, ".wr_cycle"}, 320'(cyc), 320'(e.cyc));
            checkOutput({who, ".wr_addr"}, 320'(addr), 320'(e.addr));
            checkOutput({who, ".wr_wt_data"}, wt, e.wt);
            checkOutput({who, ".wr_bias_data"}, 320'(bias), 320'(e.bias));
        end
    endtask

    task automatic gotoCycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the shared reset, per-instance start pulses (bit0 A, bit1 B, bit2 C) and B's hold.
    task automatic applyStimulus(input int n, input logic rstV, input logic [2:0] startV, input logic holdB);
        gotoCycle(n);
        reset      = rstV;
        busA.start = startV[0];
        busB.start = startV[1];
        busC.start = startV[2];
        busB.hold  = holdB;
    endtask

    // A write for address i is due D+1 = 8 cycles after its read in cycle i+1.
    task automatic pushA(input int base, input int count);
        wr_t e;
        for (int i = 0; i < count; i++) begin
            e.cyc  = base + 9 + i;
            e.addr = i;
            e.wt   = wtOf(8'(i));
            e.bias = biasOf(8'(i));
            expA.push_back(e);
        end
    endtask

    // Update-processor model: echo each cycle's read address back D=7 cycles later.
    logic [7:0] histA [0:7];
    logic [7:0] histB [0:7];
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 7; i > 0; i--) begin
                histA[i] = histA[i-1];
                histB[i] = histB[i-1];
            end
            histA[0] = 8'(busA.rd_addr);
            histB[0] = 8'(busB.rd_addr);
            busA.wt_UP_package   = wtOf(histA[7]);
            busA.bias_UP_package = biasOf(histA[7]);
            busB.wt_UP_package   = wtOf(histB[7]);
            busB.bias_UP_package = biasOf(histB[7]);
        end
    end

    // Scoreboard consumers: every observed write pops one expected entry.
    wr_t blankWr = '{cyc: -1, addr: -1, wt: '0, bias: '0};
    initial begin
        int  n;
        wr_t e;
        forever begin
            @(negedge clk);
            if (busA.wr_en === 1'b1) begin
                n = expA.size();
                e = blankWr;
                if (n != 0) e = expA.pop_front();
                checkWrite("A", n, e, 8'(busA.wr_addr), busA.wr_wt_data, busA.wr_bias_data);
            end
            if (busB.wr_en === 1'b1) begin
                n = expB.size();
                e = blankWr;
                if (n != 0) e = expB.pop_front();
                checkWrite("B", n, e, 8'(busB.wr_addr), busB.wr_wt_data, busB.wr_bias_data);
            end
            if (busC.wr_en === 1'b1) begin
                n = expC.size();
                e = blankWr;
                if (n != 0) e = expC.pop_front();
                checkWrite("C", n, e, 8'(busC.wr_addr), busC.wr_wt_data, busC.wr_bias_data);
            end
            if (busA.done === 1'b1) begin
                checkOutput("A.done_cycle", 320'(cyc), 320'(expDoneA));
                doneCntA++;
            end
            if (busB.done === 1'b1) begin
                checkOutput("B.done_cycle", 320'(cyc), 320'(expDoneB));
                doneCntB++;
            end
            if (busC.done === 1'b1) begin
                checkOutput("C.done_cycle", 320'(cyc), 320'(expDoneC));
                doneCntC++;
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wr_t e;
        int  offB [4] = '{9, 12, 13, 14};

        reset = 1'b0;
        busA.start = 1'b0; busA.hold = 1'b0;
        busB.start = 1'b0; busB.hold = 1'b0;
        busC.start = 1'b0; busC.hold = 1'b0;
        busC.wt_UP_package   = 320'h01234567;
        busC.bias_UP_package = 20'he007f;

        // Reset held low with start high: everything stays idle and zero.
        applyStimulus(2, 1'b0, 3'b111, 1'b1);
        for (int k = 2; k < 6; k++) begin
            gotoCycle(k);
            @(negedge clk);
            checkOutput("rst.A.rd_en", 320'(busA.rd_en), 320'(0));
            checkOutput("rst.A.rd_addr", 320'(busA.rd_addr), 320'(0));
            checkOutput("rst.A.busy", 320'(busA.busy), 320'(0));
            checkOutput("rst.A.done", 320'(busA.done), 320'(0));
            checkOutput("rst.A.wr_en", 320'(busA.wr_en), 320'(0));
            checkOutput("rst.A.wr_wt_data", busA.wr_wt_data, 320'(0));
            checkOutput("rst.B.busy", 320'(busB.busy), 320'(0));
            checkOutput("rst.C.rd_en", 320'(busC.rd_en), 320'(0));
        end
        applyStimulus(6, 1'b1, 3'b000, 1'b0);

        // Default pass from cycle 10, with start re-pulsed in ISSUE, DRAIN and DONE.
        applyStimulus(10, 1'b1, 3'b001, 1'b0);
        pushA(10, 64);
        expDoneA = 10 + 73;
        @(negedge clk);
        checkOutput("A.busy_c0", 320'(busA.busy), 320'(0));
        applyStimulus(11, 1'b1, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("A.busy_c1", 320'(busA.busy), 320'(1));
        checkOutput("A.rd_en_c1", 320'(busA.rd_en), 320'(1));
        checkOutput("A.rd_addr_c1", 320'(busA.rd_addr), 320'(0));
        applyStimulus(40, 1'b1, 3'b001, 1'b0);
        applyStimulus(41, 1'b1, 3'b000, 1'b0);
        applyStimulus(78, 1'b1, 3'b001, 1'b0);
        applyStimulus(79, 1'b1, 3'b000, 1'b0);
        gotoCycle(82);
        @(negedge clk);
        checkOutput("A.busy_c72", 320'(busA.busy), 320'(1));
        applyStimulus(83, 1'b1, 3'b001, 1'b0);
        @(negedge clk);
        checkOutput("A.busy_c73", 320'(busA.busy), 320'(0));

        // Start held into the IDLE cycle after done begins the second pass.
        applyStimulus(84, 1'b1, 3'b001, 1'b0);
        checkOutput("A.pass1_left", 320'(expA.size()), 320'(0));
        checkOutput("A.pass1_dones", 320'(doneCntA), 320'(1));
        pushA(84, 64);
        expDoneA = 84 + 73;
        applyStimulus(85, 1'b1, 3'b000, 1'b0);
        gotoCycle(159);
        checkOutput("A.pass2_left", 320'(expA.size()), 320'(0));
        checkOutput("A.pass2_dones", 320'(doneCntA), 320'(2));

        // Reset in cycle 20 of a pass: only addresses 0..11 get written.
        applyStimulus(165, 1'b1, 3'b001, 1'b0);
        pushA(165, 12);
        expDoneA = -1;
        applyStimulus(166, 1'b1, 3'b000, 1'b0);
        applyStimulus(185, 1'b0, 3'b000, 1'b0);
        applyStimulus(186, 1'b1, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("A.post_rst_wr_en", 320'(busA.wr_en), 320'(0));
        checkOutput("A.post_rst_busy", 320'(busA.busy), 320'(0));
        checkOutput("A.post_rst_done", 320'(busA.done), 320'(0));
        checkOutput("A.post_rst_rd_en", 320'(busA.rd_en), 320'(0));
        checkOutput("A.post_rst_wr_addr", 320'(busA.wr_addr), 320'(0));
        checkOutput("A.post_rst_wt", busA.wr_wt_data, 320'(0));
        checkOutput("A.post_rst_bias", 320'(busA.wr_bias_data), 320'(0));
        checkOutput("A.post_rst_left", 320'(expA.size()), 320'(0));
        gotoCycle(205);
        checkOutput("A.post_rst_dones", 320'(doneCntA), 320'(2));

        applyStimulus(210, 1'b1, 3'b001, 1'b0);
        pushA(210, 64);
        expDoneA = 210 + 73;
        applyStimulus(211, 1'b1, 3'b000, 1'b0);
        gotoCycle(285);
        checkOutput("A.pass3_left", 320'(expA.size()), 320'(0));
        checkOutput("A.pass3_dones", 320'(doneCntA), 320'(3));

        // depth 4 with hold in cycles 2 and 3.
        applyStimulus(290, 1'b1, 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e.cyc  = 290 + offB[i];
            e.addr = i;
            e.wt   = wtOf(8'(i));
            e.bias = biasOf(8'(i));
            expB.push_back(e);
        end
        expDoneB = 290 + 15;
        applyStimulus(291, 1'b1, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("B.rd_en_c1", 320'(busB.rd_en), 320'(1));
        applyStimulus(292, 1'b1, 3'b000, 1'b1);
        @(negedge clk);
        checkOutput("B.rd_en_hold", 320'(busB.rd_en), 320'(0));
        applyStimulus(294, 1'b1, 3'b000, 1'b0);
        @(negedge clk);
        checkOutput("B.rd_en_c4", 320'(busB.rd_en), 320'(1));
        checkOutput("B.rd_addr_c4", 320'(busB.rd_addr), 320'(1));
        gotoCycle(307);
        checkOutput("B.left", 320'(expB.size()), 320'(0));
        checkOutput("B.dones", 320'(doneCntB), 320'(1));

        // Zero-latency variant, depth 2, exact data pass-through.
        applyStimulus(310, 1'b1, 3'b100, 1'b0);
        for (int i = 0; i < 2; i++) begin
            e.cyc  = 310 + 2 + i;
            e.addr = i;
            e.wt   = 320'h01234567;
            e.bias = 20'he007f;
            expC.push_back(e);
        end
        expDoneC = 310 + 4;
        applyStimulus(311, 1'b1, 3'b000, 1'b0);
        gotoCycle(316);
        checkOutput("C.left", 320'(expC.size()), 320'(0));
        checkOutput("C.dones", 320'(doneCntC), 320'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
